// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are latched at start, an unsigned
// shift-add / restoring-divide core retires BITS_PER_CYCLE bits per cycle, and sign fix-up happens on entry to DONE.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] data_o
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            s1_q, s1_d, s2_q, s2_d, dz_q, dz_d, ovf_q, ovf_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0] a_raw_q, a_raw_d, opb_q, opb_d, lo_q, lo_d, data_q, data_d;
    logic [XLEN:0]   acc_q, acc_d;

    logic            in_div, in_sgn1, in_sgn2, in_neg1, in_neg2, in_dz, in_ovf;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        in_div  = op_i[2];
        in_sgn1 = in_div ? ~op_i[0] : (op_i != 3'b011);
        in_sgn2 = in_div ? ~op_i[0] : ~op_i[1];
        in_neg1 = in_sgn1 & data1_i[XLEN-1];
        in_neg2 = in_sgn2 & data2_i[XLEN-1];
        mag1    = in_neg1 ? -data1_i : data1_i;
        mag2    = in_neg2 ? -data2_i : data2_i;
        in_dz   = in_div && (data2_i == '0);
        in_ovf  = in_div && ~op_i[0] && (data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (data2_i == '1);
    end

    // One core step: multiply keeps the product in {acc, lo}; divide shifts the dividend out of lo.
    logic [XLEN+B-1:0] mul_sum;
    logic [XLEN:0]     div_r;
    logic [XLEN-1:0]   div_q;

    always_comb begin
        mul_sum = {{B{1'b0}}, acc_q[XLEN-1:0]};
        for (int j = 0; j < B; j++) begin
            if (lo_q[j]) mul_sum = mul_sum + ({{B{1'b0}}, opb_q} << j);
        end
        div_r = acc_q;
        div_q = lo_q;
        for (int j = 0; j < B; j++) begin
            div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
            div_q = {div_q[XLEN-2:0], 1'b0};
            if (div_r >= {1'b0, opb_q}) begin
                div_r    = div_r - {1'b0, opb_q};
                div_q[0] = 1'b1;
            end
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, rem, result;

    always_comb begin
        prod     = {acc_q[XLEN-1:0], lo_q};
        prod_fix = (s1_q ^ s2_q) ? -prod : prod;
        quot     = (s1_q ^ s2_q) ? -lo_q : lo_q;
        rem      = s1_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = dz_q ? '1 : (ovf_q ? a_raw_q : quot);
            default:                result = dz_q ? a_raw_q : (ovf_q ? '0 : rem);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        a_raw_d = a_raw_q;
        opb_d   = opb_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        data_d  = data_q;
        case (state_q)
            S_CALC: begin
                if (cnt_q == CW'(N)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    data_d  = result;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q[2]) begin
                        acc_d = div_r;
                        lo_d  = div_q;
                    end else begin
                        acc_d = {1'b0, mul_sum[XLEN+B-1:B]};
                        lo_d  = {mul_sum[B-1:0], lo_q[XLEN-1:B]};
                    end
                end
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = op_i;
                    s1_d    = in_neg1;
                    s2_d    = in_neg2;
                    dz_d    = in_dz;
                    ovf_d   = in_ovf;
                    a_raw_d = data1_i;
                    opb_d   = in_div ? mag2 : mag1;
                    lo_d    = in_div ? mag1 : mag2;
                    acc_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            a_raw_q <= '0;
            opb_q   <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            a_raw_q <= a_raw_d;
            opb_q   <= opb_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;
endmodule
